counter_mod_updown_hex: RTL and testbench
=========================================

Name: counter_mod_updown_hex

Overview:
Parametrised synchronous modulo-N up/down counter with synchronous parallel load, terminal-count and wrap flags, and a built-in multi-digit 7-segment hex readout. It generalises the team's 4-bit enable counter with single-digit decoder to arbitrary width, arbitrary modulus, and selectable direction. It drives board HEX displays directly and can be cascaded through tc/enable for wider chains.

Parameters:
WIDTH, 8, counter width in bits; multiple of 4, range 4..16; DIGITS = WIDTH/4 (derived, not overridable)
MODULUS, 256, count range 0..MODULUS-1; legal range 2..2^WIDTH
BLANK, 0, 1 = leading-zero blanking on hex output; 0 = all digits always shown

Ports:
clk  input  1  clock, all state changes on rising edge
aclr  input  1  asynchronous reset, active-low
enable  input  1  count enable; gates up/down stepping only
up  input  1  direction: 1 = increment, 0 = decrement; sampled each edge
load  input  1  synchronous parallel load strobe
d  input  WIDTH  load value
q  output  WIDTH  current count, registered
tc  output  1  terminal count, combinational
wrap  output  1  one-cycle wrap pulse, registered
hex  output  7*DIGITS  segment outputs; digit k (nibble q[4k+3:4k]) on hex[7k+6:7k]

Behaviour:
- Reset: aclr low forces q=0 and wrap=0 immediately, regardless of clk. It holds while low. The first count edge is the first rising clk with aclr high.
- Reset mid-operation: clears immediately. A pending load or count is discarded.
- Priority at each rising edge, aclr high: load > enable > hold.
- load=1: q <= d if d < MODULUS, else q <= MODULUS-1 (saturate). wrap <= 0. enable and up are ignored.
- load=0, enable=1, up=1: q <= (q == MODULUS-1) ? 0 : q+1.
- load=0, enable=1, up=0: q <= (q == 0) ? MODULUS-1 : q-1.
- load=0, enable=0: q holds, wrap <= 0.
- wrap is registered at the same edge as q.
  - wrap = 1 for exactly one cycle after an edge on which q went MODULUS-1 -> 0 (up) or 0 -> MODULUS-1 (down).
  - Otherwise wrap = 0.
- tc = enable & (up ? q == MODULUS-1 : q == 0). It is purely combinational, so it can drive the next stage's enable (cascade). It is 0 while load=1.
- Direction change: a new value of up takes effect at the next edge. There is no extra latency and no skipped value.
- q never leaves 0..MODULUS-1 under any input sequence. When MODULUS = 2^WIDTH, behaviour equals natural binary wrap.
- Latency: q and wrap change 1 edge after inputs; hex and tc follow q combinationally with no added latency.
- Segment encoding per digit is active-low, 7-bit vector ordered a..g (a = MSB of group), with nibble value -> code:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Blanking (BLANK=1): any digit above the most significant non-zero nibble outputs 1111111. Digit 0 is never blanked, so q=0 shows a single "0".
- Reset value of hex:
  - BLANK=0: all digits 0000001.
  - BLANK=1: digit 0 = 0000001, others 1111111.

Test Plan:
- WIDTH=8, MODULUS=60, up=1, enable=1 from reset, 60 edges -> q steps 0..59 then 0; wrap=1 exactly in the cycle q=0 after 59; tc=1 only while q=59.
- Same config, load=1 d=8'd75 -> q=59 next edge, wrap=0. Then up=0, enable=1, 60 edges -> q counts 59..0 then 59; wrap pulses on the 0->59 transition; tc=1 at q=0.
- Counting up at q=30, toggle up=0 for one edge, then back to 1 -> q sequence 30, 31, 30, 31; no wrap.
- aclr pulsed low between clk edges while q=42 with load=1 pending -> q=0 immediately. After release, first edge with enable=1 up=1 gives q=1. wrap stays 0 throughout.
- Load and enable simultaneous: load=1, enable=1, d=10, q=59, up=1 -> q=10, wrap=0 (load wins, no wrap).
- WIDTH=12, MODULUS=4096, BLANK=1: q=0x00A -> hex digit0=0001000, digits1-2=1111111. q=0x305 -> digit0=0100100, digit1=0000001, digit2=0000110. q=0 -> digit0=0000001, others blank.

Source files
------------

// File: rtl/counter_mod_updown_hex.sv
// Modulo-N up/down counter with synchronous load, terminal-count and wrap flags,
// and a direct-drive active-low 7-segment hex readout (one digit per nibble).
module counter_mod_updown_hex #(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 256,
  parameter bit BLANK   = 1'b0
) (
  input  logic                   clk,
  input  logic                   aclr,
  input  logic                   enable,
  input  logic                   up,
  input  logic                   load,
  input  logic [WIDTH-1:0]       d,
  output logic [WIDTH-1:0]       q,
  output logic                   tc,
  output logic                   wrap,
  output logic [7*(WIDTH/4)-1:0] hex
);

  localparam int DIGITS = WIDTH / 4;
  localparam int WP1    = WIDTH + 1;
  // MODULUS may equal 2^WIDTH, so the load range check is done one bit wider
  localparam logic [WIDTH:0]   MOD_EXT = WP1'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO_C  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C   = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next_s;
  logic             wrap_r;
  logic             wrap_next_s;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    case (nib)
      4'h0:    seg7 = 7'b0000001;
      4'h1:    seg7 = 7'b1001111;
      4'h2:    seg7 = 7'b0010010;
      4'h3:    seg7 = 7'b0000110;
      4'h4:    seg7 = 7'b1001100;
      4'h5:    seg7 = 7'b0100100;
      4'h6:    seg7 = 7'b0100000;
      4'h7:    seg7 = 7'b0001111;
      4'h8:    seg7 = 7'b0000000;
      4'h9:    seg7 = 7'b0000100;
      4'hA:    seg7 = 7'b0001000;
      4'hB:    seg7 = 7'b1100000;
      4'hC:    seg7 = 7'b0110001;
      4'hD:    seg7 = 7'b1000010;
      4'hE:    seg7 = 7'b0110000;
      4'hF:    seg7 = 7'b0111000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Next count and wrap: load (saturating) beats enable beats hold
  always_comb begin
    q_next_s    = q_r;
    wrap_next_s = 1'b0;
    if (load) begin
      if ({1'b0, d} < MOD_EXT) begin
        q_next_s = d;
      end else begin
        q_next_s = MAX_C;
      end
    end else if (enable) begin
      if (up) begin
        if (q_r == MAX_C) begin
          q_next_s    = ZERO_C;
          wrap_next_s = 1'b1;
        end else begin
          q_next_s = q_r + ONE_C;
        end
      end else begin
        if (q_r == ZERO_C) begin
          q_next_s    = MAX_C;
          wrap_next_s = 1'b1;
        end else begin
          q_next_s = q_r - ONE_C;
        end
      end
    end else begin
      q_next_s = q_r;
    end
  end

  // Count and wrap registers, cleared asynchronously by aclr
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      q_r    <= ZERO_C;
      wrap_r <= 1'b0;
    end else begin
      q_r    <= q_next_s;
      wrap_r <= wrap_next_s;
    end
  end

  assign q    = q_r;
  assign wrap = wrap_r;
  // Kept combinational so it can feed the enable of a cascaded stage
  assign tc   = enable & ~load & (up ? (q_r == MAX_C) : (q_r == ZERO_C));

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    logic [3:0] nib_s;
    assign nib_s = q_r[4*k+3:4*k];
    if (BLANK && (k > 0)) begin : g_blank
      // Digit is lit only if it or any more significant nibble is non-zero
      logic upper_nz_s;
      assign upper_nz_s      = |q_r[WIDTH-1:4*k];
      assign hex[7*k+6:7*k]  = upper_nz_s ? seg7(nib_s) : 7'b1111111;
    end else begin : g_show
      assign hex[7*k+6:7*k]  = seg7(nib_s);
    end
  end

endmodule

// File: tb/tb_counter_mod_updown_hex.sv
// Scoreboard bench: a driver pushes hand-derived expectations per edge,
// a monitor pops and compares just after every rising clock edge.
module tb_counter_mod_updown_hex;

  logic        clk = 1'b0;
  logic        aclr = 1'b0;
  logic        en_a = 1'b0, up_a = 1'b0, ld_a = 1'b0;
  logic [7:0]  d_a = 8'd0;
  logic [7:0]  q_a;
  logic        tc_a, wrap_a;
  logic [13:0] hex_a;
  logic        en_b = 1'b0, up_b = 1'b0, ld_b = 1'b0;
  logic [11:0] d_b = 12'd0;
  logic [11:0] q_b;
  logic        tc_b, wrap_b;
  logic [20:0] hex_b;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [6:0] SEG [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  localparam logic [6:0] BLK = 7'b1111111;

  typedef struct {
    bit          sel;
    logic [11:0] q;
    logic        wrap;
    logic        tc;
    logic [20:0] hex;
    string       name;
  } exp_t;

  exp_t sbq[$];

  counter_mod_updown_hex #(.WIDTH(8), .MODULUS(60), .BLANK(1'b0)) dut_a (
    .clk(clk), .aclr(aclr), .enable(en_a), .up(up_a), .load(ld_a), .d(d_a),
    .q(q_a), .tc(tc_a), .wrap(wrap_a), .hex(hex_a));

  counter_mod_updown_hex #(.WIDTH(12), .MODULUS(4096), .BLANK(1'b1)) dut_b (
    .clk(clk), .aclr(aclr), .enable(en_b), .up(up_b), .load(ld_b), .d(d_b),
    .q(q_b), .tc(tc_b), .wrap(wrap_b), .hex(hex_b));

  always #5 clk = ~clk;

  function automatic logic [13:0] hexa(input logic [7:0] v);
    return {SEG[v[7:4]], SEG[v[3:0]]};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  // Apply one cycle of stimulus to the selected counter and queue its expected response
  task automatic step(input bit sel, input bit rst_v, input bit ld, input bit en, input bit u,
                      input logic [11:0] dv, input logic [11:0] eq, input bit ew, input bit et,
                      input logic [20:0] eh, input string nm);
    exp_t e;
    @(posedge clk);
    #2;
    aclr = rst_v;
    if (!sel) begin
      ld_a = ld; en_a = en; up_a = u; d_a = dv[7:0];
      ld_b = 1'b0; en_b = 1'b0;
    end else begin
      ld_b = ld; en_b = en; up_b = u; d_b = dv;
      ld_a = 1'b0; en_a = 1'b0;
    end
    e.sel  = sel;
    e.q    = eq;
    e.wrap = ew;
    e.tc   = et;
    e.hex  = sel ? eh : {7'd0, hexa(eq[7:0])};
    e.name = nm;
    sbq.push_back(e);
  endtask

  // Monitor: compare the oldest expectation against the DUT just after each edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        exp_t e;
        e = sbq.pop_front();
        if (!e.sel) begin
          check({e.name, " q"},    32'(q_a),    32'(e.q));
          check({e.name, " wrap"}, 32'(wrap_a), 32'(e.wrap));
          check({e.name, " tc"},   32'(tc_a),   32'(e.tc));
          check({e.name, " hex"},  32'(hex_a),  32'(e.hex[13:0]));
        end else begin
          check({e.name, " q"},    32'(q_b),    32'(e.q));
          check({e.name, " wrap"}, 32'(wrap_b), 32'(e.wrap));
          check({e.name, " tc"},   32'(tc_b),   32'(e.tc));
          check({e.name, " hex"},  32'(hex_b),  32'(e.hex));
        end
      end
    end
  end

  initial begin
    #1;
    check("reset q_a",    32'(q_a),    32'd0);
    check("reset wrap_a", 32'(wrap_a), 32'd0);
    check("reset hex_a",  32'(hex_a),  32'({7'b0000001, 7'b0000001}));
    check("reset q_b",    32'(q_b),    32'd0);
    check("reset hex_b",  32'(hex_b),  32'({BLK, BLK, 7'b0000001}));
    #1;
    aclr = 1'b1;

    for (int i = 1; i <= 60; i++)
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 12'd0, 12'(i % 60), (i == 60), ((i % 60) == 59),
           21'd0, "up60");

    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 12'd75, 12'd59, 1'b0, 1'b0, 21'd0, "load sat75");
    for (int i = 1; i <= 60; i++)
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 12'd0, 12'((i < 60) ? (59 - i) : 59), (i == 60),
           (i == 59), 21'd0, "down60");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 12'd59, 1'b0, 1'b0, 21'd0, "hold wrap clr");

    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 12'd60, 12'd59, 1'b0, 1'b0, 21'd0, "load sat60");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'd0,  12'd59, 1'b0, 1'b0, 21'd0, "tc gated");
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 12'd10, 12'd10, 1'b0, 1'b0, 21'd0, "load beats en");

    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 12'd30, 12'd30, 1'b0, 1'b0, 21'd0, "load30");
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 12'd0,  12'd31, 1'b0, 1'b0, 21'd0, "dir up");
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 12'd0,  12'd30, 1'b0, 1'b0, 21'd0, "dir down");
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 12'd0,  12'd31, 1'b0, 1'b0, 21'd0, "dir up again");

    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 12'd42, 12'd42, 1'b0, 1'b0, 21'd0, "load42");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 12'd7,  12'd0,  1'b0, 1'b0, 21'd0, "aclr discards load");
    #1;
    aclr = 1'b0;
    #1;
    check("aclr async q",    32'(q_a),    32'd0);
    check("aclr async wrap", 32'(wrap_a), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 12'd0, 12'd1, 1'b0, 1'b0, 21'd0, "first edge after aclr");

    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 12'h00A, 12'h00A, 1'b0, 1'b0,
         {BLK, BLK, 7'b0001000}, "b 00A");
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 12'h305, 12'h305, 1'b0, 1'b0,
         {7'b0000110, 7'b0000001, 7'b0100100}, "b 305");
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 12'h050, 12'h050, 1'b0, 1'b0,
         {BLK, 7'b0100100, 7'b0000001}, "b 050");
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 12'h000, 12'h000, 1'b0, 1'b0,
         {BLK, BLK, 7'b0000001}, "b 000");

    for (int k = 0; (k < 10) && (sbq.size() > 0); k++) @(posedge clk);
    #2;
    if (sbq.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
